// File: rtl/nios2_multi_interval_timer.sv
// rtl/nios2_multi_interval_timer.sv - multi-channel interval timer with register slave port
module nios2_multi_interval_timer #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999,
  parameter int PRESC_W        = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_CH)+1:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);

  localparam int AW   = $clog2(NUM_CH) + 2;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  localparam logic [1:0] R_STATUS = 2'd0;
  localparam logic [1:0] R_CTRL   = 2'd1;
  localparam logic [1:0] R_PERIOD = 2'd2;
  localparam logic [1:0] R_SNAP   = 2'd3;

  // Address split: upper bits pick the channel, low two bits pick the register.
  logic [AW-1:0]   addr_ch;
  logic            ch_ok;
  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;
  logic            wr_en;
  logic [31:0]     rd_arr [NUM_CH];
  logic [31:0]     rd_next;

  assign addr_ch = address >> 2;
  assign ch_ok   = addr_ch < AW'(NUM_CH);
  assign ch_sel  = addr_ch[CH_W-1:0];
  assign reg_sel = address[1:0];
  assign wr_en   = chipselect && !write_n && ch_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0]   cnt, period, snap;
    logic [PRESC_W-1:0] presc, pcnt;
    logic               ito, cont, to, run;
    logic               wr_ch, tick, timeout;

    assign wr_ch   = wr_en && (ch_sel == CH_W'(i));
    assign tick    = run && (pcnt == presc);
    assign timeout = tick && (cnt == '0);

    // Channel state: prescaler, down-counter, flags; bus writes override the tick update.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt    <= DEF_P;
        period <= DEF_P;
        snap   <= '0;
        presc  <= '0;
        pcnt   <= '0;
        ito    <= 1'b0;
        cont   <= 1'b0;
        to     <= 1'b0;
        run    <= 1'b0;
      end else begin
        if (run) pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tick) begin
          if (timeout) begin
            cnt <= period;
            if (!cont) run <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // A timeout in the same cycle as a STATUS write keeps TO set.
        if (timeout) to <= 1'b1;
        else if (wr_ch && reg_sel == R_STATUS) to <= 1'b0;
        if (wr_ch) begin
          case (reg_sel)
            R_CTRL: begin
              ito   <= writedata[0];
              cont  <= writedata[1];
              presc <= writedata[8 +: PRESC_W];
              if (writedata[2]) begin
                run  <= 1'b1;
                pcnt <= '0;
              end else if (writedata[3]) begin
                run <= 1'b0;
              end
            end
            R_PERIOD: begin
              period <= writedata[CNT_W-1:0];
              cnt    <= writedata[CNT_W-1:0];
              run    <= 1'b0;
              pcnt   <= '0;
            end
            R_SNAP:  snap <= cnt;
            default: ;
          endcase
        end
      end
    end

    // Register view of this channel for the read mux.
    always_comb begin
      rd_arr[i] = '0;
      case (reg_sel)
        R_STATUS: rd_arr[i] = {30'd0, run, to};
        R_CTRL:   rd_arr[i] = 32'({presc, 6'd0, cont, ito});
        R_PERIOD: rd_arr[i] = 32'(period);
        default:  rd_arr[i] = 32'(snap);
      endcase
    end

    assign irq_vec[i] = to && ito;
  end

  assign irq = |irq_vec;

  // Out-of-range channels read as zero.
  always_comb begin
    rd_next = '0;
    if (ch_ok) rd_next = rd_arr[ch_sel];
  end

  // Read data is refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule

// File: tb/tb_nios2_multi_interval_timer.sv
// tb/tb_nios2_multi_interval_timer.sv - scoreboard bench for the interval timer
module tb_nios2_multi_interval_timer;

  localparam int NCH  = 3;
  localparam int AW   = $clog2(NCH) + 2;
  localparam int DEFP = 49999;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   address = '0;
  logic            chipselect = 1'b0;
  logic            write_n = 1'b1;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic            irq;
  logic [NCH-1:0]  irq_vec;

  nios2_multi_interval_timer #(
    .NUM_CH(NCH), .CNT_W(32), .DEFAULT_PERIOD(DEFP), .PRESC_W(8)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;   // 0 readdata, 1 irq_vec, 2 irq
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0:       act = readdata;
          1:       act = 32'(irq_vec);
          default: act = 32'(irq);
        endcase
        checks++;
        if (sb[i].due < cyc) begin
          failures++;
          $display("FAIL %s: expectation not sampled (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
        end else if (act !== sb[i].val) begin
          failures++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(input int d, input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.due = cyc + d; e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int ch, input int r);
    address = AW'(ch * 4 + r);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    set_addr(ch, r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] v, input string nm);
    set_addr(ch, r);
    expect_at(1, 0, v, nm);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    expect_at(1, 0, 0, "rst_readdata");
    expect_at(1, 1, 0, "rst_irq_vec");
    expect_at(1, 2, 0, "rst_irq");
    idle(2);
    reset = 1'b0;

    // Reset values and out-of-range channel
    rd(0, 2, DEFP, "p0_default");
    rd(1, 2, DEFP, "p1_default");
    rd(0, 1, 0, "ctrl0_default");
    rd(0, 0, 0, "status0_default");
    rd(2, 3, 0, "snap2_default");
    wr(3, 2, 32'h55);
    rd(3, 2, 0, "oor_period");
    rd(3, 0, 0, "oor_status");

    // Continuous period 4, presc 0: timeout every 5 clocks
    wr(0, 2, 4);
    wr(0, 1, 32'h7);
    set_addr(0, 0);
    expect_at(4, 1, 0, "cont_vec_before");
    expect_at(5, 1, 1, "cont_vec_first_to");
    expect_at(5, 0, 2, "cont_status_run");
    expect_at(6, 0, 3, "cont_status_to");
    idle(6);
    expect_at(1, 1, 0, "clr_vec_next");
    expect_at(3, 1, 0, "clr_vec_hold");
    expect_at(4, 1, 1, "cont_vec_second_to");
    expect_at(1, 0, 3, "clr_status_lag");
    expect_at(2, 0, 2, "clr_status_cleared");
    expect_at(5, 0, 3, "cont_status_second");
    wr(0, 0, 0);
    idle(4);
    wr(0, 1, 32'h8);
    wr(0, 0, 0);
    rd(0, 0, 0, "stopped_status");

    // PERIOD write while running forces reload and stop; START beats STOP
    wr(0, 2, 20);
    wr(0, 1, 32'h6);
    idle(3);
    wr(0, 2, 10);
    rd(0, 0, 0, "period_wr_stops");
    wr(0, 3, 0);
    rd(0, 3, 10, "period_wr_reload");
    wr(0, 1, 32'hC);
    rd(0, 0, 2, "start_wins");
    rd(0, 1, 0, "ctrl_start_not_stored");
    wr(0, 1, 32'h8);

    // Snapshot of a running counter
    wr(0, 2, 9);
    wr(0, 1, 32'h6);
    idle(2);
    wr(0, 3, 0);
    rd(0, 3, 7, "snap_7");
    wr(0, 3, 0);
    rd(0, 3, 5, "snap_5");
    wr(0, 1, 32'h8);

    // Channel 1 one-shot, period 3, presc 3: timeout 16 clocks after start
    wr(1, 2, 3);
    wr(1, 1, 32'h304);
    set_addr(1, 0);
    expect_at(16, 0, 2, "oneshot_before");
    expect_at(17, 0, 1, "oneshot_to_stop");
    expect_at(17, 1, 0, "oneshot_no_irq");
    expect_at(23, 0, 1, "oneshot_stays");
    idle(24);
    wr(1, 3, 0);
    rd(1, 3, 3, "oneshot_reload");
    rd(1, 1, 32'h300, "ctrl1_readback");

    // STATUS write colliding with a timeout leaves TO set
    wr(0, 2, 2);
    wr(0, 1, 32'h7);
    idle(2);
    expect_at(1, 1, 1, "vec_to_wins");
    wr(0, 0, 0);
    rd(0, 0, 3, "status_to_wins");
    wr(0, 0, 0);
    rd(0, 0, 2, "status_cleared");

    // Asynchronous reset with both channels counting
    wr(1, 1, 32'h7);
    idle(5);
    expect_at(1, 2, 1, "irq_before_reset");
    idle(1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    expect_at(0, 0, 0, "async_rst_readdata");
    expect_at(0, 1, 0, "async_rst_vec");
    expect_at(0, 2, 0, "async_rst_irq");
    @(negedge clk);
    set_addr(0, 2);
    expect_at(1, 0, 0, "readdata_in_reset");
    idle(2);
    reset = 1'b0;
    wr(1, 2, 5);
    rd(1, 2, 5, "first_write_after_reset");
    rd(0, 2, DEFP, "p0_after_reset");
    rd(0, 0, 0, "status0_after_reset");
    rd(1, 1, 0, "ctrl1_after_reset");
    rd(0, 3, 0, "snap0_after_reset");
    expect_at(1, 1, 0, "vec_after_reset");
    idle(3);

    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: never sampled (due %0d)", sb[0].name, sb[0].due);
      sb.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
